// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: writeback queue feeding the register file write port.
// Buffers ALU and LSU results in an in-order FIFO and drains one register
// write per cycle. It also exports a per-register pending bitmap for hazard
// stalls.
// Optional forwarding ports are enabled by defining the macro WB_FWD_EN.
module regfile_wb_queue #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [A_WIDTH-1:0]        alu_rd,
  input  logic [D_WIDTH-1:0]        alu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [A_WIDTH-1:0]        lsu_rd,
  input  logic [D_WIDTH-1:0]        lsu_data,
  output logic                      RegWrite,
  output logic [A_WIDTH-1:0]        rd,
  output logic [D_WIDTH-1:0]        write_data3,
  output logic [2**A_WIDTH-1:0]     pending,
`ifdef WB_FWD_EN
  input  logic [A_WIDTH-1:0]        fwd_rs1,
  input  logic [A_WIDTH-1:0]        fwd_rs2,
  output logic                      fwd_hit1,
  output logic                      fwd_hit2,
  output logic [D_WIDTH-1:0]        fwd_data1,
  output logic [D_WIDTH-1:0]        fwd_data2,
`endif
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2**A_WIDTH;

  logic [A_WIDTH-1:0] rd_mem   [DEPTH];
  logic [D_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]      count_reg, count_next;
  logic               reg_write_reg;
  logic [A_WIDTH-1:0] rd_reg;
  logic [D_WIDTH-1:0] data_reg;

  logic               lsu_push, alu_push, pop;
  logic [PW-1:0]      alu_slot;
  logic [CW-1:0]      push_cnt;
  logic [DEPTH-1:0]   occupied;

  // Readies depend only on the registered count; a pop in the same cycle
  // earns no credit. An ALU result yields the last free slot to the LSU.
  always_comb begin
    lsu_ready = (count_reg <= CW'(DEPTH - 1));
    alu_ready = lsu_valid ? (count_reg <= CW'(DEPTH - 2))
                          : (count_reg <= CW'(DEPTH - 1));
  end

  // Push/pop decisions and next-state arithmetic; x0 writes are dropped here.
  always_comb begin
    lsu_push    = lsu_valid && lsu_ready && (lsu_rd != '0);
    alu_push    = alu_valid && alu_ready && (alu_rd != '0);
    pop         = (count_reg != '0);
    alu_slot    = lsu_push ? (wr_ptr_reg + PW'(1)) : wr_ptr_reg;
    push_cnt    = CW'(lsu_push) + CW'(alu_push);
    count_next  = count_reg + push_cnt - CW'(pop);
    wr_ptr_next = wr_ptr_reg + PW'(push_cnt);
    rd_ptr_next = rd_ptr_reg + PW'(pop);
  end

  // Pointers, occupancy and the register-file output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      reg_write_reg <= 1'b0;
      rd_reg        <= '0;
      data_reg      <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (pop) begin
        reg_write_reg <= 1'b1;
        rd_reg        <= rd_mem[rd_ptr_reg];
        data_reg      <= data_mem[rd_ptr_reg];
      end else begin
        reg_write_reg <= 1'b0;
      end
    end
  end

  // Entry storage: the LSU result takes the older slot when both arrive.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (lsu_push) begin
        rd_mem[wr_ptr_reg]   <= lsu_rd;
        data_mem[wr_ptr_reg] <= lsu_data;
      end
      if (alu_push) begin
        rd_mem[alu_slot]   <= alu_rd;
        data_mem[alu_slot] <= alu_data;
      end
    end
  end

  // An entry is live when its distance from the head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
    logic [PW-1:0] offset;
    assign offset       = PW'(gi) - rd_ptr_reg;
    assign occupied[gi] = ({1'b0, offset} < count_reg);
  end

  // Pending bitmap: any live entry or the presented write targeting reg gi.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    if (gi == 0) begin : g_zero
      assign pending[gi] = 1'b0;
    end else begin : g_reg
      logic hit;
      always_comb begin
        hit = reg_write_reg && (rd_reg == A_WIDTH'(gi));
        for (int e = 0; e < DEPTH; e++) begin
          if (occupied[e] && (rd_mem[e] == A_WIDTH'(gi))) hit = 1'b1;
        end
      end
      assign pending[gi] = hit;
    end
  end

`ifdef WB_FWD_EN
  logic [A_WIDTH-1:0] fwd_rs   [2];
  logic               fwd_hit  [2];
  logic [D_WIDTH-1:0] fwd_data [2];

  assign fwd_rs[0] = fwd_rs1;
  assign fwd_rs[1] = fwd_rs2;

  // Walk from the output register through oldest to youngest entry so the
  // youngest match is the one left standing.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      logic [PW-1:0] idx;
      fwd_hit[gi]  = 1'b0;
      fwd_data[gi] = '0;
      idx          = '0;
      if (fwd_rs[gi] != '0) begin
        if (reg_write_reg && (rd_reg == fwd_rs[gi])) begin
          fwd_hit[gi]  = 1'b1;
          fwd_data[gi] = data_reg;
        end
        for (int e = 0; e < DEPTH; e++) begin
          idx = rd_ptr_reg + PW'(e);
          if ((CW'(e) < count_reg) && (rd_mem[idx] == fwd_rs[gi])) begin
            fwd_hit[gi]  = 1'b1;
            fwd_data[gi] = data_mem[idx];
          end
        end
      end
    end
  end

  assign fwd_hit1  = fwd_hit[0];
  assign fwd_hit2  = fwd_hit[1];
  assign fwd_data1 = fwd_data[0];
  assign fwd_data2 = fwd_data[1];
`endif

  assign RegWrite    = reg_write_reg;
  assign rd          = rd_reg;
  assign write_data3 = data_reg;
  assign count       = count_reg;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed vector table, hand sequences and random
// traffic, all checked against a queue-based reference model.
module tb_regfile_wb_queue;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] alu_rd, lsu_rd, rd;
  logic [DW-1:0] alu_data, lsu_data, write_data3;
  logic          RegWrite;
  logic [31:0]   pending;
  logic [2:0]    count;

  always #5 clk = ~clk;

  regfile_wb_queue #(.A_WIDTH(AW), .D_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .RegWrite(RegWrite), .rd(rd), .write_data3(write_data3),
    .pending(pending), .count(count)
  );

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic [31:0] e_pend;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t        vecs[12];
  ent_t        mq[$];
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          tests = 0;
  int          fails = 0;
  int          peak  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    if (m_rw) p[m_rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock cycle: check readies, advance model and DUT, compare outputs.
  task automatic step();
    int   sz;
    logic exp_lr, exp_ar;
    ent_t e;
    #1;
    sz     = mq.size();
    exp_lr = (sz <= DEPTH - 1);
    exp_ar = lsu_valid ? (sz <= DEPTH - 2) : (sz <= DEPTH - 1);
    chk("lsu_ready", lsu_ready, exp_lr);
    chk("alu_ready", alu_ready, exp_ar);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_rw = 0; m_rd = '0; m_data = '0;
    end else begin
      if (sz > 0) begin
        e = mq.pop_front();
        m_rw = 1; m_rd = e.rd; m_data = e.data;
      end else begin
        m_rw = 0;
      end
      if (lsu_valid && exp_lr && lsu_rd != 0) mq.push_back('{lsu_rd, lsu_data});
      if (alu_valid && exp_ar && alu_rd != 0) mq.push_back('{alu_rd, alu_data});
    end
    #1;
    chk("RegWrite", RegWrite, m_rw);
    chk("rd", rd, m_rd);
    chk("write_data3", write_data3, m_data);
    chk("count", count, mq.size());
    chk("pending", pending, model_pending());
    if (int'(count) > peak) peak = int'(count);
    if (RegWrite) $display("[TB] write rd=%0d data=%h count=%0d", rd, write_data3, count);
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    rst_n = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  initial begin
    m_rw = 0; m_rd = '0; m_data = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    //          rst av ard  adat          lv lrd ldat    rw rd dat           cnt pend
    vecs[0]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0};
    vecs[2]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0};
    vecs[3]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  0, 0, 32'h0,        1, 32'h20};
    vecs[4]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  1, 5, 32'hDEADBEEF, 0, 32'h20};
    vecs[5]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 5, 32'hDEADBEEF, 0, 32'h0};
    vecs[6]  = '{1, 1, 4, 32'h22,       1, 3, 32'h11, 0, 5, 32'hDEADBEEF, 2, 32'h18};
    vecs[7]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  1, 3, 32'h11,       1, 32'h18};
    vecs[8]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  1, 4, 32'h22,       0, 32'h10};
    vecs[9]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 4, 32'h22,       0, 32'h0};
    vecs[10] = '{1, 1, 0, 32'h55,       0, 0, 32'h0,  0, 4, 32'h22,       0, 32'h0};
    vecs[11] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 4, 32'h22,       0, 32'h0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst_n, vecs[i].av, vecs[i].ard, vecs[i].adat,
            vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
      step();
      chk($sformatf("vec%0d_rw", i), RegWrite, vecs[i].e_rw);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].e_rd);
      chk($sformatf("vec%0d_data", i), write_data3, vecs[i].e_data);
      chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("vec%0d_pending", i), pending, vecs[i].e_pend);
    end

    // Fill: both sources streaming while the drain runs, then empty out.
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 5'(i), 32'h100 + i, 1, 5'(i + 10), 32'h200 + i);
      step();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step();
    chk("fill_peak_count", peak, DEPTH - 1);
    chk("fill_drained", count, 0);

    // Reset mid-stream with three entries queued.
    drive(1, 1, 6, 32'h66, 1, 7, 32'h77); step();
    drive(1, 1, 8, 32'h88, 1, 9, 32'h99); step();
    chk("mid_fill_count", count, 3);
    drive(0, 0, 0, 0, 0, 0, 0); step();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rw", RegWrite, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_no_write", RegWrite, 0);
    end

    // Random traffic with occasional resets and frequent register collisions.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      step();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step();
    chk("final_empty", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writeback-side producer for the 32x32 register file write port (rd / RegWrite / write_data3).
- Accepts results from two execution sources, ALU and LSU, through valid/ready handshakes and buffers them in an in-order FIFO.
- Drains one register write per cycle into the register file.
- Exports a per-register pending bitmap so decode can stall on read-after-write hazards.

Parameters:
- A_WIDTH, 5: register address width; 2**A_WIDTH architectural registers.
- D_WIDTH, 32: register data width.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  queue can accept the ALU result this cycle.
- alu_rd  in  A_WIDTH  ALU destination register.
- alu_data  in  D_WIDTH  ALU result.
- lsu_valid  in  1  load result valid.
- lsu_ready  out  1  queue can accept the load result this cycle.
- lsu_rd  in  A_WIDTH  load destination register.
- lsu_data  in  D_WIDTH  load result.
- RegWrite  out  1  register file write enable (WE3).
- rd  out  A_WIDTH  register file write address (AD3).
- write_data3  out  D_WIDTH  register file write data (WD3).
- pending  out  2**A_WIDTH  bit i = 1 while a write to register i is queued or being presented.
- count  out  clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset: when rst_n=0 at a posedge, the FIFO is emptied, pointers go to 0 and count=0.
  - Outputs after reset: RegWrite=0, rd=0, write_data3=0, pending=0.
  - Reset asserted mid-operation discards all queued entries; no write is issued on the following cycle.
- Ready rules (combinational from registered count only; a same-cycle pop gives no credit):
  - lsu_ready = (count <= DEPTH-1).
  - alu_ready = lsu_valid ? (count <= DEPTH-2) : (count <= DEPTH-1).
- Transfer: occurs on a posedge where valid and ready are both high.
  - If both sources transfer in the same cycle, the LSU entry is enqueued first (older), then the ALU entry.
- x0 drop: a transfer with rd==0 completes the handshake but is not enqueued, and count does not increase for it.
- Drain:
  - At each posedge where count>0 (pre-edge value), the head entry is popped into the output registers; RegWrite=1 and rd/write_data3 = entry contents for the next cycle.
  - Otherwise RegWrite=0, and rd/write_data3 hold their previous values.
  - Push and pop may occur in the same cycle. Next count = count + pushes - pop, never above DEPTH.
- Latency: a result accepted at edge N is presented at edge N+1 when the queue was empty, and is written into the register file at edge N+2.
- Ordering: writes are issued strictly in enqueue order. Two queued writes to the same register are both issued, and the younger one's value persists.
- Full: at count==DEPTH both readies are 0. At count==DEPTH-1 only one source may be accepted, with LSU having priority.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are decided by count, not by pointer equality.
- pending (combinational): bit r is the OR of:
  - every occupied FIFO entry with rd==r;
  - (RegWrite && rd==r).
  - Bit 0 is always 0.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds these ports:
  - fwd_rs1, fwd_rs2: in, A_WIDTH.
  - fwd_hit1, fwd_hit2: out, 1.
  - fwd_data1, fwd_data2: out, D_WIDTH.
- Forwarding is combinational and reports the youngest pending value for fwd_rsN:
  - Search order is youngest FIFO entry first, then the output register.
  - hit=1 with that entry's data.
  - If no match, or fwd_rsN==0, then hit=0 and data=0.
- When the macro is undefined, these ports do not exist and there is no forwarding logic.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> RegWrite=0, rd=0, write_data3=0, count=0, pending=0, alu_ready=lsu_ready=1.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle RegWrite=1, rd=5, write_data3=0xDEADBEEF, pending[5]=1; the cycle after that RegWrite=0 and pending[5]=0.
- Simultaneous push: lsu_rd=3/0x11 and alu_rd=4/0x22 in the same cycle on an empty queue -> writes issued on consecutive cycles, rd=3 first and then rd=4.
- Fill and full:
  - Hold alu_valid=1 for 5 cycles with rd=1..5.
  - Inject a 1-cycle reset-free stall to keep the FIFO occupied, with drain active -> never more than DEPTH entries, and ready drops only when count==4.
  - All accepted writes appear in order with no loss or duplication.
- x0 drop: alu_rd=0, alu_data=0x55 -> handshake completes, count stays 0, no RegWrite pulse, pending stays 0.
- Reset mid-stream: enqueue 3 entries, assert rst_n=0 for one cycle -> count=0 and RegWrite=0 after the edge; the dropped entries are never written.
